hybrid_bpred: RTL
=================

HYBRID_BPRED -- requirements
Module: hybrid_bpred

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 Parameter XLEN, default 32: PC width.
REQ-003 Parameter IDX_W, default 6: log2 of the table depth; each table holds 2^IDX_W entries.
REQ-004 Parameter HIST_W, default 6: global history width; the legal range is 1..IDX_W.
REQ-005 clk  in  1  clock; all state SHALL change on the rising edge only.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 pred_pc  in  XLEN  fetch PC to predict.
REQ-008 pred_taken  out  1  final prediction for pred_pc.
REQ-009 pred_src  out  1  component selected: 0 = bimodal, 1 = gshare.
REQ-010 pred_ghr  out  HIST_W  current GHR snapshot, carried down the pipe with the branch.
REQ-011 upd_valid  in  1  resolved-branch update strobe.
REQ-012 upd_pc  in  XLEN  PC of the resolved branch.
REQ-013 upd_ghr  in  HIST_W  pred_ghr value captured when the branch was predicted.
REQ-014 upd_taken  in  1  actual branch outcome.
REQ-015 stat_branches, stat_mispred  out  32 each  statistics counters; present only under REQ-033.

Function
REQ-016 The block SHALL hold three tables of 2-bit saturating counters:
- bimodal table BIM
- gshare table GSH
- chooser table CHO
REQ-017 Index arithmetic SHALL be: b_idx = pc[IDX_W+1:2]; g_idx = pc[IDX_W+1:2] XOR zero-extended GHR; the chooser SHALL use b_idx.
REQ-018 Prediction SHALL be combinational from registered state with zero-cycle latency:
- p_bim = BIM[b_idx][1]
- p_gsh = GSH[g_idx][1]
- pred_src = CHO[b_idx][1]
- pred_taken = pred_src ? p_gsh : p_bim
REQ-019 The prediction path SHALL index GSH with the internal GHR; the update path SHALL index GSH with upd_ghr.
REQ-020 On upd_valid = 1, the block SHALL increment BIM[b_idx(upd_pc)] if upd_taken = 1 and decrement it otherwise, saturating at 2'b11 and 2'b00.
REQ-021 On upd_valid = 1, the block SHALL update GSH[g_idx(upd_pc, upd_ghr)] with the same rule as REQ-020.
REQ-022 The chooser SHALL update only when the pre-update component predictions at the update indices differ:
- CHO increments (saturating) when the gshare prediction equals upd_taken.
- CHO decrements (saturating) otherwise.
REQ-023 On upd_valid = 1, the GHR SHALL become {GHR[HIST_W-2:0], upd_taken}: non-speculative shift, oldest bit dropped. For HIST_W = 1, the GHR SHALL become upd_taken.
REQ-024 Same-cycle update and prediction: the prediction outputs SHALL reflect pre-edge state; there is no write-through.
REQ-025 Two updates to the same entry on consecutive cycles SHALL each apply; no update SHALL be lost.
REQ-026 With upd_valid = 0, no table or GHR state SHALL change.

Reset
REQ-027 On rst = 1 at a clock edge, every BIM and GSH entry SHALL become 2'b01 (weakly not-taken).
REQ-028 On rst = 1 at a clock edge, every CHO entry SHALL become 2'b01 (weakly bimodal).
REQ-029 On rst = 1 at a clock edge, the GHR SHALL become 0, and the statistics counters, if present, SHALL become 0.
REQ-030 After reset, the outputs SHALL be pred_taken = 0, pred_src = 0 and pred_ghr = 0 for any pred_pc.
REQ-031 rst SHALL take priority over a coincident upd_valid; that update SHALL be discarded.
REQ-032 Asserting rst mid-stream SHALL discard all training in one cycle; no sweep period SHALL exist.

Configuration
REQ-033 The macro HYBRID_BPRED_STATS_EN SHALL control the statistics feature.
- Defined: stat_branches SHALL increment on every upd_valid.
- Defined: stat_mispred SHALL increment when the final prediction recomputed at the update indices (pre-update state, upd_ghr) differs from upd_taken.
- Defined: both counters SHALL saturate at 32'hFFFF_FFFF.
- Undefined: both ports and both counters SHALL be absent, and all other behaviour SHALL be identical.

Verification (IDX_W = 6, HIST_W = 6)
REQ-034 Reset, then pred_pc = 0x100 -> pred_taken = 0, pred_src = 0, pred_ghr = 6'h00.
REQ-035 Two updates (pc 0x100, ghr 0, taken) -> BIM[0] = 2'b11, GHR = 6'h03; pred_pc 0x100 -> pred_taken = 1, pred_src = 0.
REQ-036 Five taken updates then one not-taken at pc 0x100, ghr 0 -> BIM[0] = 2'b10, pred_taken = 1; seven taken updates total -> pred_ghr = 6'h3F.
REQ-037 Chooser training sequence:
- Stimulus: two updates (pc 0x104, ghr 0, taken), then one update (pc 0x100, ghr 6'h01, taken).
- Required response: GSH[1] = 2'b11, BIM[0] = 2'b10, CHO[0] = 2'b10, pred_pc 0x100 -> pred_src = 1.
REQ-038 upd_valid and rst in the same cycle -> all tables at reset values, GHR = 0; upd_valid with pred_pc on the same index -> pred_taken shows the old value that cycle and the new value the next cycle.
REQ-039 With HYBRID_BPRED_STATS_EN defined, three updates at pc 0x100, ghr 0 (taken, taken, not-taken) from reset -> stat_branches = 3, stat_mispred = 2.

Source files
------------

// File: rtl/hybrid_bpred.sv
// Hybrid bimodal/gshare branch predictor with a 2-bit chooser and a non-speculative GHR.
// Latency: prediction is combinational (0 cycles); updates take effect on the next edge. No backpressure.
// Optional statistics counters are built when HYBRID_BPRED_STATS_EN is defined.
module hybrid_bpred #(
    parameter int XLEN   = 32,
    parameter int IDX_W  = 6,
    parameter int HIST_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_taken,
    output logic              pred_src,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_taken
`ifdef HYBRID_BPRED_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]        bim [DEPTH];
    logic [1:0]        gsh [DEPTH];
    logic [1:0]        cho [DEPTH];
    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_nxt;

    function automatic logic [IDX_W-1:0] g_index(input logic [IDX_W-1:0] b, input logic [HIST_W-1:0] h);
        logic [IDX_W-1:0] ext;
        ext             = '0;
        ext[HIST_W-1:0] = h;
        return b ^ ext;
    endfunction

    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up && c != 2'b11)
            r = c + 2'd1;
        else if (!up && c != 2'b00)
            r = c - 2'd1;
        return r;
    endfunction

    logic [IDX_W-1:0] p_bidx, p_gidx, u_bidx, u_gidx;
    logic             u_pbim, u_pgsh, u_final;

    assign p_bidx = pred_pc[IDX_W+1:2];
    assign p_gidx = g_index(p_bidx, ghr);
    assign u_bidx = upd_pc[IDX_W+1:2];
    assign u_gidx = g_index(u_bidx, upd_ghr);

    assign pred_src   = cho[p_bidx][1];
    assign pred_taken = pred_src ? gsh[p_gidx][1] : bim[p_bidx][1];
    assign pred_ghr   = ghr;

    // Component predictions at the update indices, taken from pre-update state.
    assign u_pbim  = bim[u_bidx][1];
    assign u_pgsh  = gsh[u_gidx][1];
    assign u_final = cho[u_bidx][1] ? u_pgsh : u_pbim;

    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_nxt = upd_taken;
        end else begin : g_histn
            assign ghr_nxt = {ghr[HIST_W-2:0], upd_taken};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bim[i] <= 2'b01;
                gsh[i] <= 2'b01;
                cho[i] <= 2'b01;
            end
            ghr <= '0;
        end else if (upd_valid) begin
            bim[u_bidx] <= sat_step(bim[u_bidx], upd_taken);
            gsh[u_gidx] <= sat_step(gsh[u_gidx], upd_taken);
            // Chooser only learns when the two components disagreed.
            if (u_pbim != u_pgsh)
                cho[u_bidx] <= sat_step(cho[u_bidx], u_pgsh == upd_taken);
            ghr <= ghr_nxt;
        end
    end

`ifdef HYBRID_BPRED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else if (upd_valid) begin
            if (stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (u_final != upd_taken && stat_mispred != 32'hFFFF_FFFF)
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
    logic unused_final;
    assign unused_final = 1'b0;
`else
    logic unused_final;
    assign unused_final = u_final;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0], unused_final};

endmodule
